multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_if.sv | 35 +++
 rtl/multicycle_ctrl.sv | 176 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Handshake/bus bundle between the multicycle controller and its datapath/stimulus.
// The master side supplies instruction fields and ALU status; the slave side
// (the controller) returns control strobes and status.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 16
) ();
    logic             en;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic             zero;
    logic             PCWrite;
    logic             PCSrc;
    logic             ALUSrc;
    logic [4:0]       ALU_operation;
    logic             RegWrite;
    logic             write;
    logic             MemtoReg;
    logic [2:0]       state;
    logic             inst_done;
    logic             halted;
    logic [CNT_W-1:0] inst_count;

    modport master (
        output en, opcode, funct3, funct7b5, zero,
        input  PCWrite, PCSrc, ALUSrc, ALU_operation, RegWrite, write,
               MemtoReg, state, inst_done, halted, inst_count
    );

    modport slave (
        input  en, opcode, funct3, funct7b5, zero,
        output PCWrite, PCSrc, ALUSrc, ALU_operation, RegWrite, write,
               MemtoReg, state, inst_done, halted, inst_count
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style control unit: FETCH/DECODE/EXEC/MEM/WB sequencing,
// instruction field latch, retired-instruction counter and illegal-op halt.
// Control outputs are decoded from the registered state and latched fields.
module multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    multicycle_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_e;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_XOR = 5'd4;
    localparam logic [4:0] ALU_SLL = 5'd5;
    localparam logic [4:0] ALU_SRL = 5'd6;
    localparam logic [4:0] ALU_SLT = 5'd7;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    state_e           state_q;
    logic [6:0]       opcode_q;
    logic [2:0]       funct3_q;
    logic             funct7b5_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic       is_r, is_i, is_lw, is_sw, is_br;
    logic       alu_ok, legal;
    logic [4:0] alu_dec;

    logic       pc_write, pc_src, alu_src, reg_write, mem_write, mem_to_reg, done;
    logic [4:0] alu_op;

    // Instruction class, taken only from the fields captured in FETCH
    assign is_r  = (opcode_q == OP_R);
    assign is_i  = (opcode_q == OP_I);
    assign is_lw = (opcode_q == OP_LW) && (funct3_q == 3'b010);
    assign is_sw = (opcode_q == OP_SW) && (funct3_q == 3'b010);
    assign is_br = (opcode_q == OP_BR) && (funct3_q[2:1] == 2'b00);
    assign legal = ((is_r || is_i) && alu_ok) || is_lw || is_sw || is_br;

    // ALU function decode shared by R and I-ALU; SUB exists only in the R form
    always_comb begin
        alu_ok  = 1'b1;
        alu_dec = ALU_ADD;
        case (funct3_q)
            3'b000: alu_dec = (is_r && funct7b5_q) ? ALU_SUB : ALU_ADD;
            3'b111: alu_dec = ALU_AND;
            3'b110: alu_dec = ALU_OR;
            3'b100: alu_dec = ALU_XOR;
            3'b001: alu_dec = ALU_SLL;
            3'b101: begin
                alu_dec = ALU_SRL;
                alu_ok  = ~funct7b5_q;   // arithmetic shift is not supported
            end
            3'b010: alu_dec = ALU_SLT;
            default: alu_ok = 1'b0;
        endcase
    end

    // Control strobes per state; WB repeats the EXEC ALU setting so the result stays stable
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_EXEC: begin
                if (is_lw || is_sw) begin
                    alu_src = 1'b1;
                end else if (is_br) begin
                    alu_op   = ALU_SUB;
                    pc_write = 1'b1;
                    pc_src   = funct3_q[0] ? ~bus.zero : bus.zero;
                    done     = 1'b1;
                end else begin
                    alu_src = is_i;
                    alu_op  = alu_dec;
                end
            end
            S_MEM: begin
                alu_src = 1'b1;
                if (is_sw) begin
                    mem_write = 1'b1;
                    pc_write  = 1'b1;
                    done      = 1'b1;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                done       = 1'b1;
                mem_to_reg = ~is_lw;
                if (is_lw) begin
                    alu_src = 1'b1;
                end else begin
                    alu_src = is_i;
                    alu_op  = alu_dec;
                end
            end
            default: ;
        endcase
    end

    assign count_d = count_q + CNT_W'(1);

    // Sequencer, field latch and retirement counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            opcode_q   <= '0;
            funct3_q   <= '0;
            funct7b5_q <= 1'b0;
            count_q    <= '0;
        end else begin
            if (done) begin
                count_q <= count_d;
            end
            case (state_q)
                S_FETCH: begin
                    if (bus.en) begin
                        opcode_q   <= bus.opcode;
                        funct3_q   <= bus.funct3;
                        funct7b5_q <= bus.funct7b5;
                        state_q    <= S_DECODE;
                    end
                end
                S_DECODE: state_q <= legal ? S_EXEC : S_HALT;
                S_EXEC: begin
                    if (is_br) begin
                        state_q <= S_FETCH;
                    end else if (is_lw || is_sw) begin
                        state_q <= S_MEM;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM:   state_q <= is_lw ? S_WB : S_FETCH;
                S_WB:    state_q <= S_FETCH;
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign bus.PCWrite       = pc_write;
    assign bus.PCSrc         = pc_src;
    assign bus.ALUSrc        = alu_src;
    assign bus.ALU_operation = alu_op;
    assign bus.RegWrite      = reg_write;
    assign bus.write         = mem_write;
    assign bus.MemtoReg      = mem_to_reg;
    assign bus.state         = state_q;
    assign bus.inst_done     = done;
    assign bus.halted        = (state_q == S_HALT);
    assign bus.inst_count    = count_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, hand-written
// corner sequences (halt, counter wrap, reset during MEM) and random instructions
// checked cycle-by-cycle against an instruction-level reference model.
module tb_multicycle_ctrl;
    localparam int CW = 4;

    localparam int K_ILL = 0;
    localparam int K_R   = 1;
    localparam int K_I   = 2;
    localparam int K_LW  = 3;
    localparam int K_SW  = 4;
    localparam int K_BEQ = 5;
    localparam int K_BNE = 6;

    logic clk = 1'b0;
    logic reset;

    multicycle_ctrl_if #(.CNT_W(CW)) bus ();

    multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       pcw;
        logic       pcs;
        logic       asrc;
        logic [4:0] aop;
        logic       regw;
        logic       wr;
        logic       m2r;
        logic       done;
        logic       halted;
    } obs_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        int         lat;
        logic [4:0] aop;
        logic       asrc;
        logic       pcs;
    } vec_t;

    int   n_checks  = 0;
    int   n_fail    = 0;
    int   model_cnt = 0;
    int   alu_tab [8];
    obs_t trace_q [$];
    vec_t vecs [15];

    function automatic obs_t observe();
        obs_t o;
        o.st     = bus.state;
        o.pcw    = bus.PCWrite;
        o.pcs    = bus.PCSrc;
        o.asrc   = bus.ALUSrc;
        o.aop    = bus.ALU_operation;
        o.regw   = bus.RegWrite;
        o.wr     = bus.write;
        o.m2r    = bus.MemtoReg;
        o.done   = bus.inst_done;
        o.halted = bus.halted;
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual st/pcw/pcs/asrc/aop/regw/wr/m2r/done/halt=%b required=%b",
                     name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Instruction classification straight from the legal-set rules
    function automatic int ref_kind(input logic [6:0] op, input logic [2:0] f3,
                                    input logic f7, output logic [4:0] aop);
        aop = 5'd0;
        case (op)
            7'b0110011, 7'b0010011: begin
                if (alu_tab[f3] < 0) return K_ILL;
                if (f3 == 3'b101 && f7) return K_ILL;
                aop = 5'(alu_tab[f3]);
                if (op == 7'b0110011 && f3 == 3'b000 && f7) aop = 5'd1;
                return (op == 7'b0110011) ? K_R : K_I;
            end
            7'b0000011: return (f3 == 3'b010) ? K_LW : K_ILL;
            7'b0100011: return (f3 == 3'b010) ? K_SW : K_ILL;
            7'b1100011: begin
                if (f3 == 3'b000) return K_BEQ;
                if (f3 == 3'b001) return K_BNE;
                return K_ILL;
            end
            default: return K_ILL;
        endcase
    endfunction

    // Expected per-cycle outputs for one instruction, starting with its FETCH cycle
    task automatic build_trace(input int kind, input logic [4:0] aop, input logic z, input int halt_n);
        obs_t o;
        trace_q.delete();
        o = '0;
        trace_q.push_back(o);
        o.st = 3'd1;
        trace_q.push_back(o);
        if (kind == K_ILL) begin
            for (int n = 0; n < halt_n; n++) begin
                o = '0; o.st = 3'd7; o.halted = 1'b1;
                trace_q.push_back(o);
            end
            return;
        end
        o = '0; o.st = 3'd2;
        case (kind)
            K_R, K_I: begin
                o.asrc = (kind == K_I); o.aop = aop;
                trace_q.push_back(o);
                o.st = 3'd4; o.regw = 1'b1; o.pcw = 1'b1; o.m2r = 1'b1; o.done = 1'b1;
                trace_q.push_back(o);
            end
            K_LW: begin
                o.asrc = 1'b1;
                trace_q.push_back(o);
                o.st = 3'd3;
                trace_q.push_back(o);
                o.st = 3'd4; o.regw = 1'b1; o.pcw = 1'b1; o.done = 1'b1;
                trace_q.push_back(o);
            end
            K_SW: begin
                o.asrc = 1'b1;
                trace_q.push_back(o);
                o.st = 3'd3; o.wr = 1'b1; o.pcw = 1'b1; o.done = 1'b1;
                trace_q.push_back(o);
            end
            default: begin
                o.aop = 5'd1; o.pcw = 1'b1; o.done = 1'b1;
                o.pcs = (kind == K_BEQ) ? z : ~z;
                trace_q.push_back(o);
            end
        endcase
    endtask

    // Runs one instruction from FETCH; called and returns at posedge+1
    task automatic exec_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                              input logic z, input int halt_n, output int lat, output obs_t exec_obs);
        int         kind;
        logic [4:0] aop;
        obs_t       act;
        kind = ref_kind(op, f3, f7, aop);
        build_trace(kind, aop, z, halt_n);
        lat = -1;
        exec_obs = '0;
        bus.zero = z;
        for (int i = 0; i < trace_q.size(); i++) begin
            if (i == 0) begin
                bus.en = 1'b1; bus.opcode = op; bus.funct3 = f3; bus.funct7b5 = f7;
            end else begin
                bus.en       = 1'($urandom_range(0, 1));
                bus.opcode   = 7'($urandom);
                bus.funct3   = 3'($urandom);
                bus.funct7b5 = 1'($urandom);
            end
            #1;
            act = observe();
            check_obs($sformatf("op%b_f3%b cyc%0d", op, f3, i), act, trace_q[i]);
            if (act.done && lat < 0) lat = i + 1;
            if (i == 2) exec_obs = act;
            if (trace_q[i].done) model_cnt = (model_cnt + 1) % (1 << CW);
            @(posedge clk); #1;
        end
        bus.en = 1'b0;
        check_int("inst_count", int'(bus.inst_count), model_cnt);
        $display("instr op=%b f3=%b f7=%b zero=%b kind=%0d lat=%0d count=%0d",
                 op, f3, f7, z, kind, lat, bus.inst_count);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.en = 1'b0; bus.opcode = 7'($urandom); bus.funct3 = 3'($urandom);
            #1;
            check_obs("idle_fetch", observe(), '0);
            @(posedge clk); #1;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        check_obs("reset_outputs", observe(), '0);
        check_int("reset_count", int'(bus.inst_count), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        model_cnt = 0;
    endtask

    initial begin
        int         lat;
        obs_t       eo;
        int         kind;
        logic [4:0] aop;
        logic [6:0] ops [5];

        alu_tab = '{0, 5, 7, -1, 4, 6, 3, 2};
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
        vecs[0]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 4, 5'd0, 1'b0, 1'b0}; // ADD
        vecs[1]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 4, 5'd1, 1'b0, 1'b0}; // SUB
        vecs[2]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 4, 5'd0, 1'b1, 1'b0}; // ADDI
        vecs[3]  = '{7'b0110011, 3'b101, 1'b0, 1'b0, 4, 5'd6, 1'b0, 1'b0}; // SRL
        vecs[4]  = '{7'b0010011, 3'b010, 1'b0, 1'b0, 4, 5'd7, 1'b1, 1'b0}; // SLTI
        vecs[5]  = '{7'b0110011, 3'b111, 1'b0, 1'b0, 4, 5'd2, 1'b0, 1'b0}; // AND
        vecs[6]  = '{7'b0010011, 3'b110, 1'b0, 1'b0, 4, 5'd3, 1'b1, 1'b0}; // ORI
        vecs[7]  = '{7'b0110011, 3'b100, 1'b0, 1'b0, 4, 5'd4, 1'b0, 1'b0}; // XOR
        vecs[8]  = '{7'b0010011, 3'b001, 1'b0, 1'b0, 4, 5'd5, 1'b1, 1'b0}; // SLLI
        vecs[9]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 5, 5'd0, 1'b1, 1'b0}; // LW
        vecs[10] = '{7'b0100011, 3'b010, 1'b0, 1'b0, 4, 5'd0, 1'b1, 1'b0}; // SW
        vecs[11] = '{7'b1100011, 3'b000, 1'b0, 1'b1, 3, 5'd1, 1'b0, 1'b1}; // BEQ taken
        vecs[12] = '{7'b1100011, 3'b001, 1'b0, 1'b1, 3, 5'd1, 1'b0, 1'b0}; // BNE not taken
        vecs[13] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 3, 5'd1, 1'b0, 1'b0}; // BEQ not taken
        vecs[14] = '{7'b1100011, 3'b001, 1'b0, 1'b0, 3, 5'd1, 1'b0, 1'b1}; // BNE taken

        reset = 1'b0;
        bus.en = 1'b0; bus.opcode = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
        #2;
        check_obs("por_outputs", observe(), '0);
        check_int("por_count", int'(bus.inst_count), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        idle(2);

        // Directed vector table
        foreach (vecs[v]) begin
            exec_instr(vecs[v].op, vecs[v].f3, vecs[v].f7, vecs[v].z, 0, lat, eo);
            check_int($sformatf("vec%0d latency", v), lat, vecs[v].lat);
            check_int($sformatf("vec%0d exec_aluop", v), int'(eo.aop), int'(vecs[v].aop));
            check_int($sformatf("vec%0d exec_alusrc", v), int'(eo.asrc), int'(vecs[v].asrc));
            check_int($sformatf("vec%0d exec_pcsrc", v), int'(eo.pcs), int'(vecs[v].pcs));
        end

        // Illegal opcode: halt, strobes quiet for 10 cycles, reset clears it
        apply_reset();
        exec_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 10, lat, eo);
        check_int("halt_no_done", lat, -1);
        check_int("halt_flag", int'(bus.halted), 1);
        apply_reset();
        idle(1);

        // Counter wrap with a 4-bit counter
        apply_reset();
        for (int n = 0; n < 15; n++) exec_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, lat, eo);
        check_int("wrap_pre", int'(bus.inst_count), 15);
        exec_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, lat, eo);
        check_int("wrap_post", int'(bus.inst_count), 0);

        // Reset during the MEM cycle of SW aborts it without a store or retirement
        apply_reset();
        kind = ref_kind(7'b0100011, 3'b010, 1'b0, aop);
        build_trace(kind, aop, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            bus.en = (i == 0); bus.opcode = 7'b0100011; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0;
            #1;
            check_obs($sformatf("sw_abort cyc%0d", i), observe(), trace_q[i]);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        check_obs("sw_abort_mem", observe(), '0);
        check_int("sw_abort_cnt", int'(bus.inst_count), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        model_cnt = 0;
        #1;
        check_obs("sw_abort_after", observe(), '0);
        idle(2);
        check_int("sw_abort_cnt_end", int'(bus.inst_count), 0);

        // Random instructions against the reference model
        for (int r = 0; r < 40; r++) begin
            logic [6:0] op;
            logic [2:0] f3;
            logic       f7, z;
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 4)];
            f3 = ($urandom_range(0, 1) == 0 && op != 7'b0110011 && op != 7'b0010011)
                 ? 3'b010 : 3'($urandom);
            if (op == 7'b1100011) f3 = 3'($urandom_range(0, 2));
            f7 = 1'($urandom);
            z  = 1'($urandom);
            kind = ref_kind(op, f3, f7, aop);
            exec_instr(op, f3, f7, z, 3, lat, eo);
            if (kind == K_ILL) apply_reset();
            idle($urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
